// File: rtl/data_memory_param.sv
// data_memory_param: DEPTH x DATA_W data memory with a hardware clear sequencer that fills every word with INIT_VAL after reset.
// Latency: reads are registered (R_data/R_valid one cycle after the request edge); writes commit at the request edge.
// Backpressure: none; requests arriving while busy=1 are silently dropped. Macro DMEM_BYPASS_EN selects write-first same-address collisions.
module data_memory_param #(
   parameter int                DATA_W   = 4,
   parameter int                ADDR_W   = 4,
   parameter int                DEPTH    = 16,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              D_rd,
   input  logic              D_wr,
   input  logic [ADDR_W-1:0] D_addr,
   input  logic [DATA_W-1:0] W_data,
   output logic [DATA_W-1:0] R_data,
   output logic              R_valid,
   output logic              busy
);

   // One extra bit so DEPTH == 2**ADDR_W is representable in the bound check.
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] clr_idx;
   logic [ADDR_W-1:0] clr_idx_nxt;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   logic              addr_in_range;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              rd_accept;
   logic [DATA_W-1:0] rd_word;

   assign addr_in_range = ({1'b0, D_addr} < DEPTH_EXT);

   // State and clear-index registers; reset restarts the fill from word 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_CLEAR;
         clr_idx <= '0;
      end else begin
         state   <= state_nxt;
         clr_idx <= clr_idx_nxt;
      end
   end

   // Next-state logic and the single write-port mux shared by the clear fill and datapath writes.
   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      mem_we      = 1'b0;
      mem_waddr   = clr_idx;
      mem_wdata   = INIT_VAL;
      rd_accept   = 1'b0;
      busy        = 1'b0;
      case (state)
         ST_CLEAR: begin
            busy   = 1'b1;
            mem_we = 1'b1;
            if (clr_idx == LAST_IDX) begin
               state_nxt   = ST_IDLE;
               clr_idx_nxt = '0;
            end else begin
               clr_idx_nxt = clr_idx + ADDR_W'(1);
            end
         end
         ST_IDLE: begin
            rd_accept = D_rd;
            // Out-of-range writes are dropped rather than aliased onto a real word.
            if (D_wr && addr_in_range) begin
               mem_we    = 1'b1;
               mem_waddr = D_addr;
               mem_wdata = W_data;
            end
         end
         default: begin
            state_nxt = ST_CLEAR;
         end
      endcase
   end

   // Memory array write; suppressed on a reset edge so reset never disturbs stored data.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Read-data selection: out-of-range reads return zero; same-address collision policy is build-selected.
   always_comb begin
      rd_word = '0;
      if (addr_in_range) begin
`ifdef DMEM_BYPASS_EN
         if (D_wr) begin
            rd_word = W_data;
         end else begin
            rd_word = mem[D_addr];
         end
`else
         rd_word = mem[D_addr];
`endif
      end
   end

   // Registered read port: R_valid pulses per accepted read, R_data holds between reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         R_data  <= '0;
         R_valid <= 1'b0;
      end else begin
         R_valid <= rd_accept;
         if (rd_accept) begin
            R_data <= rd_word;
         end
      end
   end

endmodule

// File: tb/tb_data_memory_param.sv
// tb_data_memory_param: exercises a 16-word and a 12-word instance side by side with shared stimulus.
// Expected values come from constants and a word-array model of the memory plus a clear countdown.
// Each task checks its own scenario; a random phase compares every output every cycle.
module tb_data_memory_param;

`ifdef DMEM_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif
   localparam logic [3:0] INIT = 4'h5;

   logic       clk;
   logic       reset;
   logic       D_rd;
   logic       D_wr;
   logic [3:0] D_addr;
   logic [3:0] W_data;
   logic [3:0] r_data16, r_data12;
   logic       r_valid16, r_valid12;
   logic       busy16, busy12;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: index 0 is the 16-word instance, index 1 the 12-word instance.
   logic [3:0] mm [2][16];
   int         clr [2];
   logic [3:0] er [2];
   logic       ev [2];

   data_memory_param #(.DATA_W(4), .ADDR_W(4), .DEPTH(16), .INIT_VAL(INIT)) u_dut16 (
      .clk(clk), .reset(reset), .D_rd(D_rd), .D_wr(D_wr), .D_addr(D_addr), .W_data(W_data),
      .R_data(r_data16), .R_valid(r_valid16), .busy(busy16));

   data_memory_param #(.DATA_W(4), .ADDR_W(4), .DEPTH(12), .INIT_VAL(INIT)) u_dut12 (
      .clk(clk), .reset(reset), .D_rd(D_rd), .D_wr(D_wr), .D_addr(D_addr), .W_data(W_data),
      .R_data(r_data12), .R_valid(r_valid12), .busy(busy12));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int d;
         d = (k == 0) ? 16 : 12;
         if (reset) begin
            clr[k] = d;
            ev[k]  = 1'b0;
            er[k]  = 4'h0;
         end else if (clr[k] > 0) begin
            mm[k][d - clr[k]] = INIT;
            clr[k] = clr[k] - 1;
            ev[k]  = 1'b0;
         end else begin
            ev[k] = D_rd;
            if (D_rd) begin
               if (int'(D_addr) >= d)   er[k] = 4'h0;
               else if (D_wr && BYPASS) er[k] = W_data;
               else                     er[k] = mm[k][D_addr];
            end
            if (D_wr && int'(D_addr) < d) mm[k][D_addr] = W_data;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      D_rd = 1'b0; D_wr = 1'b0; D_addr = 4'h0; W_data = 4'h0;
   endtask

   task automatic test_reset();
      int cnt16, cnt12;
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if (busy16 !== 1'b1 || r_valid16 !== 1'b0 || r_data16 !== 4'h0)
         $display("FAIL reset_state16: busy=%b valid=%b data=%h, need busy=1 valid=0 data=0", busy16, r_valid16, r_data16);
      else n_pass++;
      n_checks++;
      if (busy12 !== 1'b1 || r_valid12 !== 1'b0 || r_data12 !== 4'h0)
         $display("FAIL reset_state12: busy=%b valid=%b data=%h, need busy=1 valid=0 data=0", busy12, r_valid12, r_data12);
      else n_pass++;
      cnt16 = 0; cnt12 = 0;
      for (int i = 0; i < 24; i++) begin
         if (busy16 === 1'b1) cnt16++;
         if (busy12 === 1'b1) cnt12++;
         tick();
      end
      n_checks++;
      if (cnt16 != 16) $display("FAIL clear_len16: busy cycles %0d, need 16", cnt16);
      else n_pass++;
      n_checks++;
      if (cnt12 != 12) $display("FAIL clear_len12: busy cycles %0d, need 12", cnt12);
      else n_pass++;
   endtask

   task automatic test_clear_values();
      for (int i = 0; i < 16; i++) begin
         D_rd = 1'b1; D_addr = 4'(i);
         tick();
         n_checks++;
         if (r_valid16 !== 1'b1 || r_data16 !== INIT)
            $display("FAIL clear_read16[%0d]: valid=%b data=%h, need valid=1 data=%h", i, r_valid16, r_data16, INIT);
         else n_pass++;
         n_checks++;
         if (r_valid12 !== 1'b1 || r_data12 !== ((i < 12) ? INIT : 4'h0))
            $display("FAIL clear_read12[%0d]: valid=%b data=%h, need valid=1 data=%h", i, r_valid12, r_data12, (i < 12) ? INIT : 4'h0);
         else n_pass++;
      end
      idle_inputs();
      tick();
      n_checks++;
      if (r_valid16 !== 1'b0 || r_data16 !== INIT)
         $display("FAIL read_hold: valid=%b data=%h, need valid=0 data=%h", r_valid16, r_data16, INIT);
      else n_pass++;
   endtask

   task automatic test_write_read();
      D_wr = 1'b1; D_addr = 4'd8; W_data = 4'hF;
      tick();
      D_wr = 1'b0; D_rd = 1'b1;
      tick();
      n_checks++;
      if (r_valid16 !== 1'b1 || r_data16 !== 4'hF || r_data12 !== 4'hF)
         $display("FAIL write_read8: valid=%b data16=%h data12=%h, need valid=1 data=f", r_valid16, r_data16, r_data12);
      else n_pass++;
      D_addr = 4'd7;
      tick();
      n_checks++;
      if (r_valid16 !== 1'b1 || r_data16 !== INIT)
         $display("FAIL neighbour7: valid=%b data=%h, need valid=1 data=%h", r_valid16, r_data16, INIT);
      else n_pass++;
      idle_inputs();
      tick();
   endtask

   task automatic test_collision();
      logic [3:0] need;
      D_wr = 1'b1; D_addr = 4'd3; W_data = 4'h2;
      tick();
      D_rd = 1'b1; W_data = 4'hA;
      tick();
      need = BYPASS ? 4'hA : 4'h2;
      n_checks++;
      if (r_valid16 !== 1'b1 || r_data16 !== need)
         $display("FAIL collision: valid=%b data=%h, need valid=1 data=%h", r_valid16, r_data16, need);
      else n_pass++;
      D_wr = 1'b0;
      tick();
      n_checks++;
      if (r_valid16 !== 1'b1 || r_data16 !== 4'hA)
         $display("FAIL after_collision: valid=%b data=%h, need valid=1 data=a", r_valid16, r_data16);
      else n_pass++;
      idle_inputs();
      tick();
   endtask

   task automatic test_busy_drop();
      int bad;
      idle_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         D_wr = (i % 2 == 0); D_rd = (i % 2 == 1);
         D_addr = (i % 2 == 0) ? 4'd0 : 4'd1; W_data = 4'h9;
         tick();
         if (r_valid16 !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL busy_valid: R_valid high in %0d busy cycles, need 0", bad);
      else n_pass++;
      n_checks++;
      if (busy16 !== 1'b0) $display("FAIL busy_end: busy=%b, need 0", busy16);
      else n_pass++;
      D_wr = 1'b0; D_rd = 1'b1; D_addr = 4'd0;
      tick();
      n_checks++;
      if (r_valid16 !== 1'b1 || r_data16 !== INIT)
         $display("FAIL busy_write_dropped: valid=%b data=%h, need valid=1 data=%h", r_valid16, r_data16, INIT);
      else n_pass++;
      idle_inputs();
      tick();
   endtask

   task automatic test_out_of_range();
      D_wr = 1'b1; D_addr = 4'd13; W_data = 4'h7;
      tick();
      D_wr = 1'b0; D_rd = 1'b1;
      tick();
      n_checks++;
      if (r_valid12 !== 1'b1 || r_data12 !== 4'h0)
         $display("FAIL oor_read12: valid=%b data=%h, need valid=1 data=0", r_valid12, r_data12);
      else n_pass++;
      n_checks++;
      if (r_valid16 !== 1'b1 || r_data16 !== 4'h7)
         $display("FAIL inrange_read16: valid=%b data=%h, need valid=1 data=7", r_valid16, r_data16);
      else n_pass++;
      for (int i = 0; i < 12; i++) begin
         D_addr = 4'(i);
         tick();
         n_checks++;
         if (r_valid12 !== 1'b1 || r_data12 !== er[1])
            $display("FAIL oor_unchanged[%0d]: valid=%b data=%h, need valid=1 data=%h", i, r_valid12, r_data12, er[1]);
         else n_pass++;
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      int cnt;
      D_rd = 1'b1; D_addr = 4'd8; reset = 1'b1;
      tick();
      reset = 1'b0; D_rd = 1'b0;
      n_checks++;
      if (r_valid16 !== 1'b0 || r_data16 !== 4'h0 || busy16 !== 1'b1)
         $display("FAIL reset_mid: valid=%b data=%h busy=%b, need valid=0 data=0 busy=1", r_valid16, r_data16, busy16);
      else n_pass++;
      cnt = 0;
      for (int i = 0; i < 24; i++) begin
         if (busy16 === 1'b1) cnt++;
         tick();
      end
      n_checks++;
      if (cnt != 16) $display("FAIL reset_mid_clear: busy cycles %0d, need 16", cnt);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         reset  = ($urandom_range(0, 79) == 0);
         D_rd   = 1'($urandom_range(0, 1));
         D_wr   = 1'($urandom_range(0, 1));
         D_addr = 4'($urandom_range(0, 15));
         W_data = 4'($urandom);
         tick();
         n_checks++;
         if (busy16 !== (clr[0] > 0) || r_valid16 !== ev[0] || r_data16 !== er[0])
            $display("FAIL rand16 cyc %0d: busy=%b valid=%b data=%h, need busy=%b valid=%b data=%h",
                     i, busy16, r_valid16, r_data16, clr[0] > 0, ev[0], er[0]);
         else n_pass++;
         n_checks++;
         if (busy12 !== (clr[1] > 0) || r_valid12 !== ev[1] || r_data12 !== er[1])
            $display("FAIL rand12 cyc %0d: busy=%b valid=%b data=%h, need busy=%b valid=%b data=%h",
                     i, busy12, r_valid12, r_data12, clr[1] > 0, ev[1], er[1]);
         else n_pass++;
      end
      reset = 1'b0;
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_clear_values();
      test_write_read();
      test_collision();
      test_busy_drop();
      test_out_of_range();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
